// File: rtl/decoder_stream.sv
// Streaming binary-to-one-hot decoder with a 2-entry output FIFO and a
// saturating accepted-code counter.
module decoder_stream #(
  parameter int IN_W  = 3,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_code,
  input  logic                   in_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(1<<IN_W)-1:0]   out_y,
  output logic [CNT_W-1:0]       count
);
  localparam int OUT_W = 1 << IN_W;

  logic [1:0]       occ;
  logic [OUT_W-1:0] head, tail, word;
  logic             acc, drn;

  assign in_ready  = !rst && (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign out_y     = head;
  assign acc       = in_valid && in_ready;
  assign drn       = out_valid && out_ready;

  always_comb begin
    word = '0;
    if (in_en) word[in_code] = 1'b1;
  end

  // head/tail are kept zero whenever unoccupied, so out_y is zero when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ   <= 2'd0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({acc, drn})
        2'b10: begin
          if (occ == 2'd0) head <= word;
          else             tail <= word;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          tail <= '0;
          occ  <= occ - 2'd1;
        end
        // accept is only possible alongside a drain when occ == 1
        2'b11:   head <= word;
        default: ;
      endcase
      if (acc && (count != {CNT_W{1'b1}})) count <= count + 1'b1;
    end
  end
endmodule
